// File: rtl/mem_arbiter_if.sv
// Data memory bus: one request/response channel.
// Masters drive the request side, slaves answer.
interface mem_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto one data bus,
// with a watchdog that aborts unanswered transfers.
module mem_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic          timeout_err,
  output logic          busy
);

  localparam int WW =
    (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WW-1:0] WD_LAST =
    WW'(TIMEOUT - 1);
  localparam bit WD_ON = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY0,
    BUSY1
  } state_t;

  state_t        state, state_nx;
  logic          last_grant, lg_nx;
  logic [WW-1:0] wdog, wdog_nx;
  logic          gnt;
  logic          req_valid;
  logic          wd_fire;

  // State, round-robin pointer and watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wdog       <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= lg_nx;
      wdog       <= wdog_nx;
    end
  end

  // Arbitration, bus mux and completion/abort decisions.
  always_comb begin
    state_nx    = state;
    lg_nx       = last_grant;
    wdog_nx     = wdog;
    busy        = 1'b0;
    timeout_err = 1'b0;
    s.valid     = 1'b0;
    s.addr      = '0;
    s.wdata     = '0;
    s.wstrb     = '0;
    m0.ready    = 1'b0;
    m0.rdata    = '0;
    m1.ready    = 1'b0;
    m1.rdata    = '0;
    gnt         = (state == BUSY1);
    req_valid   = gnt ? m1.valid : m0.valid;
    wd_fire     = 1'b0;

    unique case (state)
      IDLE: begin
        wdog_nx = '0;
        if (m0.valid && (!m1.valid || last_grant))
          state_nx = BUSY0;
        else if (m1.valid)
          state_nx = BUSY1;
      end
      BUSY0, BUSY1: begin
        busy    = 1'b1;
        s.valid = req_valid;
        s.addr  = gnt ? m1.addr  : m0.addr;
        s.wdata = gnt ? m1.wdata : m0.wdata;
        s.wstrb = gnt ? m1.wstrb : m0.wstrb;
        // A real s_ready always beats the watchdog.
        wd_fire = WD_ON && (wdog == WD_LAST)
                  && !s.ready && req_valid;
        timeout_err = wd_fire;
        if (gnt) begin
          m1.ready = s.ready || wd_fire;
          m1.rdata = wd_fire ? ERR_RDATA : s.rdata;
        end else begin
          m0.ready = s.ready || wd_fire;
          m0.rdata = wd_fire ? ERR_RDATA : s.rdata;
        end
        if (s.ready || !req_valid || wd_fire) begin
          state_nx = IDLE;
          lg_nx    = gnt;
          wdog_nx  = '0;
        end else begin
          wdog_nx = wdog + WW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // Keep the buses quiet while reset is held.
    if (reset) begin
      busy        = 1'b0;
      timeout_err = 1'b0;
      s.valid     = 1'b0;
      s.addr      = '0;
      s.wdata     = '0;
      s.wstrb     = '0;
      m0.ready    = 1'b0;
      m0.rdata    = '0;
      m1.ready    = 1'b0;
      m1.rdata    = '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter against a
// transaction-level round-robin/watchdog model.
module tb_mem_arbiter;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset;
  logic timeout_err;
  logic busy;

  mem_arbiter_if m0_if ();
  mem_arbiter_if m1_if ();
  mem_arbiter_if s_if ();

  mem_arbiter #(
    .TIMEOUT  (TMO),
    .ERR_RDATA(ERR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m0         (m0_if.slave),
    .m1         (m1_if.slave),
    .s          (s_if.master),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          last_g;
  logic [31:0] a  [2];
  logic [31:0] d  [2];
  logic [3:0]  st [2];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int m, input bit v,
                         input logic [31:0] ad,
                         input logic [31:0] wd,
                         input logic [3:0] sb);
    a[m]  = ad;
    d[m]  = wd;
    st[m] = sb;
    if (m == 0) begin
      m0_if.valid = v;
      m0_if.addr  = ad;
      m0_if.wdata = wd;
      m0_if.wstrb = sb;
    end else begin
      m1_if.valid = v;
      m1_if.addr  = ad;
      m1_if.wdata = wd;
      m1_if.wstrb = sb;
    end
  endtask

  // Round robin: the master that was not served last wins a tie.
  function automatic int pick(input bit v0, input bit v1);
    if (v0 && v1) return (last_g == 1) ? 0 : 1;
    return v0 ? 0 : 1;
  endfunction

  // Slave answers lat cycles after s_valid rises; the
  // watchdog ends the transfer in the TMO-th busy cycle.
  task automatic serve(input int lat,
                       input logic [31:0] rd,
                       input int m);
    int          kend;
    logic [31:0] exp_rd;
    logic        own_r, oth_r;
    logic [31:0] own_d, oth_d;
    kend   = (lat < TMO) ? lat : TMO - 1;
    exp_rd = (lat < TMO) ? rd : ERR;
    for (int k = 0; k <= kend; k++) begin
      s_if.ready = (k == lat);
      s_if.rdata = rd;
      #1;
      own_r = (m == 1) ? m1_if.ready : m0_if.ready;
      oth_r = (m == 1) ? m0_if.ready : m1_if.ready;
      own_d = (m == 1) ? m1_if.rdata : m0_if.rdata;
      oth_d = (m == 1) ? m0_if.rdata : m1_if.rdata;
      check("s_valid", s_if.valid, 1);
      check("busy", busy, 1);
      if (k == 0) begin
        check("s_addr", s_if.addr, a[m]);
        check("s_wdata", s_if.wdata, d[m]);
        check("s_wstrb", s_if.wstrb, st[m]);
      end
      check("own_ready", own_r, k == kend);
      check("other_ready", oth_r, 0);
      check("timeout_err", timeout_err,
            (k == kend) && (lat >= TMO));
      if (k == kend) begin
        check("own_rdata", own_d, exp_rd);
        check("other_rdata", oth_d, 0);
      end
      tick();
    end
    s_if.ready = 1'b0;
    last_g = m;
  endtask

  initial begin
    int r;
    int exp_m;
    reset      = 1'b1;
    s_if.ready = 1'b0;
    s_if.rdata = 32'h5555AAAA;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (3) tick();
    #1;
    check("rst_s_valid", s_if.valid, 0);
    check("rst_s_addr", s_if.addr, 0);
    check("rst_s_wdata", s_if.wdata, 0);
    check("rst_s_wstrb", s_if.wstrb, 0);
    check("rst_m0_ready", m0_if.ready, 0);
    check("rst_m1_ready", m1_if.ready, 0);
    check("rst_m0_rdata", m0_if.rdata, 0);
    check("rst_m1_rdata", m1_if.rdata, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_busy", busy, 0);
    reset  = 1'b0;
    last_g = 1;
    tick();

    // single read, slave latency 2
    set_req(0, 1, 32'h100, 0, 4'h0);
    #1;
    check("idle_gap_s_valid", s_if.valid, 0);
    tick();
    serve(2, 32'h12345678, pick(1, 0));
    #1;
    check("rd_done_busy", busy, 0);
    check("rd_done_m0_ready", m0_if.ready, 0);
    set_req(0, 0, 0, 0, 0);

    // simultaneous, continuously held requests
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    last_g = 1;
    set_req(0, 1, 32'h1000_0000, $urandom, 4'hF);
    set_req(1, 1, 32'h2000_0000, $urandom, 4'h3);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_idle_s_valid", s_if.valid, 0);
      tick();
      exp_m = pick(1, 1);
      serve(0, $urandom, exp_m);
      set_req(exp_m, 1,
              32'h1000_0000 * (exp_m + 1) + i + 1,
              $urandom, 4'h0);
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);

    // write from m1 only
    set_req(1, 1, 32'h2004, 32'hCAFEBABE, 4'b1100);
    #1;
    tick();
    serve(1, 32'h0, pick(0, 1));
    set_req(1, 0, 0, 0, 0);

    // watchdog: slave never answers
    set_req(0, 1, 32'h300, 0, 4'h0);
    #1;
    tick();
    serve(99, 32'h11111111, pick(1, 0));
    #1;
    check("wd_after_s_valid", s_if.valid, 0);
    check("wd_after_tmo", timeout_err, 0);
    set_req(0, 0, 0, 0, 0);

    // watchdog: s_ready in the timeout cycle
    set_req(0, 1, 32'h304, 0, 4'h0);
    #1;
    tick();
    serve(TMO - 1, 32'h22222222, pick(1, 0));
    set_req(0, 0, 0, 0, 0);

    // reset while m1 is being served
    set_req(1, 1, 32'h400, 32'h4, 4'h1);
    #1;
    tick();
    #1;
    check("mid_busy1", busy, 1);
    reset = 1'b1;
    tick();
    #1;
    check("mid_rst_s_valid", s_if.valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_m1_ready", m1_if.ready, 0);
    reset  = 1'b0;
    last_g = 1;
    set_req(0, 1, 32'h500, 0, 4'h0);
    set_req(1, 1, 32'h404, 0, 4'h0);
    #1;
    check("post_rst_idle", busy, 0);
    tick();
    serve(0, $urandom, pick(1, 1));
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);

    // m0 withdraws its request before s_ready
    set_req(0, 1, 32'h600, 0, 4'h0);
    #1;
    tick();
    #1;
    check("abort_s_valid_on", s_if.valid, 1);
    set_req(0, 0, 32'h600, 0, 4'h0);
    set_req(1, 1, 32'h700, 32'h77, 4'hF);
    #1;
    check("abort_s_valid_off", s_if.valid, 0);
    check("abort_m0_ready", m0_if.ready, 0);
    tick();
    #1;
    check("abort_idle", busy, 0);
    last_g = 0;
    set_req(0, 1, 32'h604, 0, 4'h0);
    tick();
    serve(0, $urandom, pick(1, 1));
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);

    // random request patterns and slave latencies
    repeat (30) begin
      r = $urandom_range(1, 3);
      set_req(0, r[0], $urandom, $urandom,
              4'($urandom_range(0, 15)));
      set_req(1, r[1], $urandom, $urandom,
              4'($urandom_range(0, 15)));
      #1;
      check("rnd_idle_busy", busy, 0);
      tick();
      exp_m = pick(r[0], r[1]);
      serve($urandom_range(0, 5), $urandom, exp_m);
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
